uart_cmd_parser: RTL

Byte-level command parser that sits directly behind the UART receiver in the motor-PID design. It assembles 5-byte command frames from received bytes, checks sync, address range and checksum, and issues single-cycle register write strobes to the PID/motor register file (setpoint, Kp, Ki, Kd, mode). It also aborts stalled frames using a bit-tick timeout and keeps a saturating error counter for host diagnostics.

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_parser_timeout.sv | 36 +++
 rtl/uart_cmd_parser.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared constants, state encoding and register map for the
//                UART command parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] CMD_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        ADDR = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CHK  = 3'd4
    } cmd_state_t;

    localparam logic [3:0] SETPOINT = 4'd0;
    localparam logic [3:0] KP       = 4'd1;
    localparam logic [3:0] KI       = 4'd2;
    localparam logic [3:0] KD       = 4'd3;
    localparam logic [3:0] MODE     = 4'd4;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_timeout
//  Description : Tick-counting watchdog; flags expiry on the tick that would
//                bring the count to TIMEOUT_TICKS.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout #(
    parameter int TIMEOUT_TICKS = 480
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int             CW     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0]  c_last = CW'(TIMEOUT_TICKS - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && i_tick) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Combinational so the registered error strobe lands one cycle after the tick.
    assign o_expire = i_enable && i_tick && !i_clear && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Assembles 5-byte command frames from UART bytes and issues
//                register write strobes or error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 480,
    parameter int NUM_REGS      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick16,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_framing_error,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        pkt_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam logic [8:0] c_num_regs = 9'(NUM_REGS);

    cmd_state_t  r_state,     w_state_nxt;
    logic [3:0]  r_addr,      w_addr_nxt;
    logic [7:0]  r_dhi,       w_dhi_nxt;
    logic [7:0]  r_dlo,       w_dlo_nxt;
    logic [7:0]  r_xor,       w_xor_nxt;
    logic        r_wr_en,     w_wr_en_nxt;
    logic        r_pkt_err,   w_pkt_err_nxt;
    logic [3:0]  r_wr_addr,   w_wr_addr_nxt;
    logic [15:0] r_wr_data,   w_wr_data_nxt;
    logic [7:0]  r_err_count, w_err_count_nxt;
    logic        w_expire;
    logic        w_in_hunt;

    assign w_in_hunt = (r_state == HUNT);

    cmd_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (tick16),
        .i_clear  (rx_valid || w_in_hunt),
        .i_enable (!w_in_hunt),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_addr      <= '0;
            r_dhi       <= '0;
            r_dlo       <= '0;
            r_xor       <= '0;
            r_wr_en     <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_dhi       <= w_dhi_nxt;
            r_dlo       <= w_dlo_nxt;
            r_xor       <= w_xor_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_pkt_err   <= w_pkt_err_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // Priority: framing error, then received byte, then timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_dhi_nxt       = r_dhi;
        w_dlo_nxt       = r_dlo;
        w_xor_nxt       = r_xor;
        w_wr_en_nxt     = 1'b0;
        w_pkt_err_nxt   = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;

        if (!w_in_hunt && rx_framing_error) begin
            w_pkt_err_nxt = 1'b1;
            w_state_nxt   = HUNT;
        end else if (rx_valid) begin
            case (r_state)
                HUNT: begin
                    if (rx_data == CMD_SYNC) begin
                        w_state_nxt = ADDR;
                        w_xor_nxt   = '0;
                    end
                end
                ADDR: begin
                    if ({1'b0, rx_data} < c_num_regs) begin
                        w_addr_nxt  = rx_data[3:0];
                        w_xor_nxt   = r_xor ^ rx_data;
                        w_state_nxt = DHI;
                    end else begin
                        w_pkt_err_nxt = 1'b1;
                        w_state_nxt   = HUNT;
                    end
                end
                DHI: begin
                    w_dhi_nxt   = rx_data;
                    w_xor_nxt   = r_xor ^ rx_data;
                    w_state_nxt = DLO;
                end
                DLO: begin
                    w_dlo_nxt   = rx_data;
                    w_xor_nxt   = r_xor ^ rx_data;
                    w_state_nxt = CHK;
                end
                CHK: begin
                    if (rx_data == r_xor) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = {r_dhi, r_dlo};
                    end else begin
                        w_pkt_err_nxt = 1'b1;
                    end
                    w_state_nxt = HUNT;
                end
                default: w_state_nxt = HUNT;
            endcase
        end else if (w_expire) begin
            w_pkt_err_nxt = 1'b1;
            w_state_nxt   = HUNT;
        end

        w_err_count_nxt = r_err_count;
        if (w_pkt_err_nxt && (r_err_count != 8'hFF)) begin
            w_err_count_nxt = r_err_count + 8'd1;
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign pkt_err   = r_pkt_err;
    assign err_count = r_err_count;
    assign busy      = !w_in_hunt;

endmodule
`default_nettype wire
